// File: rtl/apb2axi_tag_sched.sv
// Tag lifecycle controller for the APB2AXI transaction directory: allocates tags,
// tracks EMPTY/ALLOCATED/PENDING/ISSUED/COMPLETE per tag and round-robin issues PENDING tags.
module apb2axi_tag_sched #(
  parameter int TAG_NUM = 16,
  parameter int TAG_W   = $clog2(TAG_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_req,
  output logic               alloc_gnt,
  output logic [TAG_W-1:0]   alloc_tag,
  input  logic               commit_valid,
  input  logic [TAG_W-1:0]   commit_tag,
  output logic               issue_valid,
  output logic [TAG_W-1:0]   issue_tag,
  input  logic               issue_ready,
  input  logic               cpl_valid,
  input  logic [TAG_W-1:0]   cpl_tag,
  input  logic               rel_valid,
  input  logic [TAG_W-1:0]   rel_tag,
  output logic [TAG_W:0]     free_count,
  output logic               err_illegal,
  output logic [TAG_NUM-1:0] busy_vec
);

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_ALLOC  = 3'd1,
    ST_PEND   = 3'd2,
    ST_ISSUED = 3'd3,
    ST_CPL    = 3'd4
  } tag_state_t;

  tag_state_t         state_reg  [TAG_NUM];
  tag_state_t         state_next [TAG_NUM];
  logic               issue_valid_reg;
  logic [TAG_W-1:0]   issue_tag_reg;
  logic [TAG_W-1:0]   rr_ptr_reg;
  logic [TAG_W:0]     free_count_reg;
  logic [TAG_W:0]     free_count_next;
  logic               err_reg;
  logic [TAG_NUM-1:0] busy_reg;
  logic [TAG_NUM-1:0] busy_next;

  logic             any_empty;
  logic [TAG_W-1:0] low_empty;
  logic             commit_ok, commit_bad;
  logic             cpl_in_slot, cpl_ok, cpl_bad;
  logic             rel_ok, rel_bad;
  logic             sel_en, sel_found;
  logic [TAG_W-1:0] sel_tag;
  logic [TAG_W-1:0] sel_idx;

  // Scan downward so the last hit is the lowest EMPTY index.
  always_comb begin
    any_empty = 1'b0;
    low_empty = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--) begin
      if (state_reg[i] == ST_EMPTY) begin
        any_empty = 1'b1;
        low_empty = TAG_W'(i);
      end
    end
  end

  assign alloc_gnt = alloc_req && any_empty;
  assign alloc_tag = low_empty;

  assign commit_ok   = commit_valid && (state_reg[commit_tag] == ST_ALLOC);
  assign commit_bad  = commit_valid && (state_reg[commit_tag] != ST_ALLOC);
  assign cpl_in_slot = issue_valid_reg && (issue_tag_reg == cpl_tag);
  assign cpl_ok      = cpl_valid && (state_reg[cpl_tag] == ST_ISSUED) && !cpl_in_slot;
  assign cpl_bad     = cpl_valid && !cpl_ok;
  assign rel_ok      = rel_valid && (state_reg[rel_tag] == ST_CPL);
  assign rel_bad     = rel_valid && !rel_ok;

  assign sel_en = !issue_valid_reg || issue_ready;

  // Round-robin search starting just after the last issued tag; k=TAG_NUM wraps onto rr_ptr itself.
  always_comb begin
    sel_found = 1'b0;
    sel_tag   = '0;
    sel_idx   = '0;
    for (int k = 1; k <= TAG_NUM; k++) begin
      sel_idx = rr_ptr_reg + TAG_W'(k);
      if (!sel_found && (state_reg[sel_idx] == ST_PEND)) begin
        sel_found = 1'b1;
        sel_tag   = sel_idx;
      end
    end
  end

  // Each port acts only on a distinct prior state, so the updates never collide on one tag.
  always_comb begin
    for (int i = 0; i < TAG_NUM; i++) begin
      state_next[i] = state_reg[i];
    end
    if (alloc_gnt)            state_next[low_empty]  = ST_ALLOC;
    if (commit_ok)            state_next[commit_tag] = ST_PEND;
    if (cpl_ok)               state_next[cpl_tag]    = ST_CPL;
    if (rel_ok)               state_next[rel_tag]    = ST_EMPTY;
    if (sel_en && sel_found)  state_next[sel_tag]    = ST_ISSUED;
  end

  for (genvar gi = 0; gi < TAG_NUM; gi++) begin : g_busy
    assign busy_next[gi] = (state_next[gi] != ST_EMPTY);
  end

  assign free_count_next = free_count_reg + {{TAG_W{1'b0}}, rel_ok} - {{TAG_W{1'b0}}, alloc_gnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        state_reg[i] <= ST_EMPTY;
      end
      issue_valid_reg <= 1'b0;
      issue_tag_reg   <= '0;
      rr_ptr_reg      <= TAG_W'(TAG_NUM - 1);
      free_count_reg  <= (TAG_W + 1)'(TAG_NUM);
      err_reg         <= 1'b0;
      busy_reg        <= '0;
    end else begin
      for (int i = 0; i < TAG_NUM; i++) begin
        state_reg[i] <= state_next[i];
      end
      if (sel_en) begin
        issue_valid_reg <= sel_found;
        if (sel_found) begin
          issue_tag_reg <= sel_tag;
          rr_ptr_reg    <= sel_tag;
        end
      end
      free_count_reg <= free_count_next;
      err_reg        <= commit_bad || cpl_bad || rel_bad;
      busy_reg       <= busy_next;
    end
  end

  assign issue_valid = issue_valid_reg;
  assign issue_tag   = issue_tag_reg;
  assign free_count  = free_count_reg;
  assign err_illegal = err_reg;
  assign busy_vec    = busy_reg;

endmodule

// File: tb/tb_apb2axi_tag_sched.sv
// Randomized bench for apb2axi_tag_sched against a per-tag lifecycle model kept as plain integers.
module tb_apb2axi_tag_sched;

  localparam int N = 16;
  localparam int W = 4;
  localparam int E = 0, A = 1, P = 2, I = 3, C = 4;

  logic         clk, rst;
  logic         alloc_req, alloc_gnt;
  logic [W-1:0] alloc_tag;
  logic         commit_valid;
  logic [W-1:0] commit_tag;
  logic         issue_valid, issue_ready;
  logic [W-1:0] issue_tag;
  logic         cpl_valid, rel_valid;
  logic [W-1:0] cpl_tag, rel_tag;
  logic [W:0]   free_count;
  logic         err_illegal;
  logic [N-1:0] busy_vec;

  apb2axi_tag_sched #(.TAG_NUM(N)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .rel_valid(rel_valid), .rel_tag(rel_tag),
    .free_count(free_count), .err_illegal(err_illegal), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int st [N];
  bit m_valid;
  int m_tag, m_rr;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int count_state(input int s);
    int n = 0;
    for (int t = 0; t < N; t++) if (st[t] == s) n++;
    return n;
  endfunction

  function automatic int lowest_empty();
    for (int t = 0; t < N; t++) if (st[t] == E) return t;
    return 0;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = 0;
    for (int t = 0; t < N; t++) if (st[t] != E) b[t] = 1'b1;
    return b;
  endfunction

  function automatic int pick(input int want);
    int cand[$];
    for (int t = 0; t < N; t++) if (st[t] == want) cand.push_back(t);
    if (cand.size() == 0 || $urandom_range(9) == 0) return int'($urandom_range(N - 1));
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  task automatic model_reset();
    for (int t = 0; t < N; t++) st[t] = E;
    m_valid = 0; m_tag = 0; m_rr = N - 1; m_err = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    int nst [N];
    bit gnt;
    int at;
    gnt = alloc_req && (count_state(E) > 0);
    at  = lowest_empty();
    nst = st;
    m_err = 0;
    if (gnt) nst[at] = A;
    if (commit_valid) begin
      if (st[commit_tag] == A) nst[commit_tag] = P; else m_err = 1;
    end
    if (cpl_valid) begin
      if (st[cpl_tag] == I && !(m_valid && m_tag == int'(cpl_tag))) nst[cpl_tag] = C; else m_err = 1;
    end
    if (rel_valid) begin
      if (st[rel_tag] == C) nst[rel_tag] = E; else m_err = 1;
    end
    if (!m_valid || issue_ready) begin
      bit found = 0;
      for (int k = 1; k <= N && !found; k++) begin
        int idx = (m_rr + k) % N;
        if (st[idx] == P) begin
          found = 1; nst[idx] = I; m_tag = idx; m_rr = idx;
        end
      end
      m_valid = found;
    end
    st = nst;
  endtask

  task automatic check_regs(input string where);
    check({where, "_valid"}, 32'(issue_valid), 32'(m_valid));
    if (m_valid) check({where, "_tag"}, 32'(issue_tag), 32'(m_tag));
    check({where, "_free"}, 32'(free_count), 32'(count_state(E)));
    check({where, "_err"}, 32'(err_illegal), 32'(m_err));
    check({where, "_busy"}, 32'(busy_vec), model_busy());
  endtask

  task automatic step();
    #1;
    check("alloc_gnt", 32'(alloc_gnt), 32'(alloc_req && (count_state(E) > 0)));
    check("alloc_tag", 32'(alloc_tag), 32'(lowest_empty()));
    @(posedge clk);
    #1;
    model_update();
    check_regs("cyc");
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alloc_req = 0; commit_valid = 0; commit_tag = 0; issue_ready = 0;
    cpl_valid = 0; cpl_tag = 0; rel_valid = 0; rel_tag = 0;
  endtask

  task automatic check_reset_vals(input string where);
    check({where, "_valid"}, 32'(issue_valid), 0);
    check({where, "_tag"}, 32'(issue_tag), 0);
    check({where, "_free"}, 32'(free_count), N);
    check({where, "_err"}, 32'(err_illegal), 0);
    check({where, "_busy"}, 32'(busy_vec), 0);
  endtask

  int ready_pct;

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    #1;
    check_reset_vals("rst0");
    @(negedge clk);
    rst = 1'b0;

    // Three back-to-back allocations from a fresh directory.
    for (int k = 0; k < 3; k++) begin
      alloc_req = 1;
      #1 check("dir_atag", 32'(alloc_tag), k);
      step();
    end
    alloc_req = 0;
    check("dir_free13", 32'(free_count), 13);
    check("dir_busy7", 32'(busy_vec), 32'h0007);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        // Assert reset between edges with traffic in flight.
        idle_inputs();
        #2 rst = 1'b1;
        #1 check_reset_vals("midrst");
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
      end
      case ((cyc / 150) % 3)
        0: ready_pct = 100;
        1: ready_pct = 10;
        default: ready_pct = 60;
      endcase
      alloc_req    = ($urandom_range(99) < 60);
      commit_valid = ($urandom_range(99) < 50);
      commit_tag   = W'(pick(A));
      cpl_valid    = ($urandom_range(99) < 40);
      cpl_tag      = W'(pick(I));
      rel_valid    = ($urandom_range(99) < 30);
      rel_tag      = W'(pick(C));
      issue_ready  = ($urandom_range(99) < ready_pct);
      step();
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
